inv_datapath: RTL and testbench
===============================

Name: inv_datapath

Overview:
- GF(2^M) inversion datapath (Itoh-Tsujii style) driven cycle by cycle by the 5-bit inversion control word from the inversion controller.
- Shares the alu_o_sel start strobe with the controller; each control word is applied in the cycle it is presented.
- Contains operand/accumulator registers, a 2^(2^k) power unit and a fixed-latency pipelined GF multiplier.
- Returns the final accumulator with a one-cycle valid pulse when the controller's terminal word lands.

Parameters:
- M, 13, field degree.
- POLY, 13'h001B, reduction polynomial low terms (x^13 + x^4 + x^3 + x + 1).
- MUL_LAT, 4, multiplier pipeline depth in cycles.
- TERM, 5'b01100, terminal control word.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- alu_o_sel  in  1  start strobe; a rising edge starts an inversion.
- inv_cSignal  in  5  control word {in_sel[4], in_en[3], mux0_sel[2], pow_sel[1:0]}.
- op_in  in  M  operand to invert; sampled on an initial load.
- res_out  out  M  accumulator register T.
- res_valid  out  1  one-cycle pulse: result ready.
- busy  out  1  inversion in progress.

Behaviour:
- Reset (rst=1 at posedge): T, B, all multiplier pipe stages, prev_o, busy and res_valid are 0. Reset overrides every other event.
- Start detection: prev_o <= alu_o_sel every cycle. The start condition is {prev_o, alu_o_sel} == 01.
  - Start sets busy=1 at the next edge.
  - A start while already busy restarts: busy stays 1 and T/B are untouched until the next load.
- Power unit (combinational), P = T^(2^k):
  - pow_sel 00: k=1.
  - pow_sel 01: k=3.
  - pow_sel 1x: k=6.
- Multiplier:
  - Operand A = mux0_sel ? P : T. Operand B = register B.
  - Product is reduced mod POLY. mul_out in cycle n equals A*B for the operands of cycle n-MUL_LAT.
  - The pipe advances every cycle regardless of busy.
- Register update, only when busy=1 and in_en=1:
  - in_sel=1: T <= op_in, B <= op_in.
  - in_sel=0: T <= mul_out, B <= mul_out.
  - in_en=0, or busy=0: T and B hold.
- Termination: in a cycle with busy=1, inv_cSignal==TERM and no start:
  - the TERM update is applied;
  - busy <= 0;
  - res_valid=1 in the following cycle only.
  - Later TERM words (the controller holds TERM) are ignored because busy=0.
- Start coinciding with TERM: start wins. busy stays 1, no res_valid, and the TERM update is still applied.
- res_valid is 0 in all other cycles. res_out = T at all times and is stable while busy=0.
- Nominal timing: start detected in cycle 0; words 1..26 in cycles 1..26; load from mul_out in cycle 5j+1 consumes the operands of cycle 5j-3 (MUL_LAT=4); res_valid in cycle 27.

Test Plan:
- Reset with rst=1 for 2 cycles -> res_out=0, res_valid=0, busy=0; while idle, words 11000 with op_in=0x1234 leave T=0.
- Square: start; op_in=0x1000; word 11000 in cycle 1; 00000 in cycles 2-5; 01000 in cycle 6 -> T=0x185A from cycle 7; busy=1; no res_valid.
- Power-3: start; op_in=0x0002; word 11000 in cycle 1; 00101 in cycles 2-5; 01000 in cycle 6 -> T=0x0200 (x^9).
- Full controller sequence (words 1..26, TERM held after) with op_in=0x0001:
  - res_out=0x0001;
  - res_valid high in cycle 27 only;
  - busy falls after cycle 26;
  - no further pulse while TERM persists for 20 cycles.
- Restart: second rising edge of alu_o_sel in cycle 12 -> busy stays 1, no res_valid at cycle 27; res_valid arrives 27 cycles after the second start.
- Reset mid-operation: rst=1 in cycle 10 -> T=0, busy=0; subsequent words including TERM produce no res_valid and no T change.

Source files
------------

// File: rtl/inv_datapath_if.sv
// Control/data bundle between the inversion controller and the GF(2^M) inversion datapath.
// The controller side is the master; the datapath side is the slave.
interface inv_datapath_if #(
  parameter int unsigned M = 13
) ();
  logic         alu_o_sel;
  logic [4:0]   inv_cSignal;
  logic [M-1:0] op_in;
  logic [M-1:0] res_out;
  logic         res_valid;
  logic         busy;

  modport master (
    output alu_o_sel,
    output inv_cSignal,
    output op_in,
    input  res_out,
    input  res_valid,
    input  busy
  );

  modport slave (
    input  alu_o_sel,
    input  inv_cSignal,
    input  op_in,
    output res_out,
    output res_valid,
    output busy
  );
endinterface

// File: rtl/inv_datapath.sv
// Itoh-Tsujii GF(2^M) inversion datapath: T/B registers, a T^(2^k) power unit and a
// MUL_LAT-deep pipelined field multiplier, sequenced by the controller's 5-bit word.
module inv_datapath #(
  parameter int unsigned    M       = 13,
  parameter logic [M-1:0]   POLY    = 13'h001B,
  parameter int unsigned    MUL_LAT = 4,
  parameter logic [4:0]     TERM    = 5'b01100
) (
  input logic           clk,
  input logic           rst,
  inv_datapath_if.slave bus
);

  // Shift-and-add multiply with reduction folded into each shift (x^M == POLY).
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < int'(M); i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[M-1] ? ((sh << 1) ^ POLY) : (sh << 1);
    end
    return acc;
  endfunction

  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    return gf_mul(a, a);
  endfunction

  logic         in_sel;
  logic         in_en;
  logic         mux0_sel;
  logic [1:0]   pow_sel;

  logic [M-1:0] t_q, t_d;
  logic [M-1:0] b_q, b_d;
  // Stage 0 sits in the low M bits; the oldest product is the top slice.
  logic [MUL_LAT*M-1:0] pipe_q, pipe_d;
  logic         prev_o_q, prev_o_d;
  logic         busy_q, busy_d;
  logic         res_valid_q, res_valid_d;

  logic         start;
  logic         term_hit;
  logic [M-1:0] pow1, pow3, pow6;
  logic [M-1:0] pow_out;
  logic [M-1:0] mul_a;
  logic [M-1:0] mul_out;

  assign {in_sel, in_en, mux0_sel, pow_sel} = bus.inv_cSignal;

  always_comb begin
    pow1 = gf_sq(t_q);
    pow3 = gf_sq(gf_sq(pow1));
    pow6 = gf_sq(gf_sq(gf_sq(pow3)));
    unique case (pow_sel)
      2'b00:   pow_out = pow1;
      2'b01:   pow_out = pow3;
      default: pow_out = pow6;
    endcase
  end

  assign mul_a   = mux0_sel ? pow_out : t_q;
  assign mul_out = pipe_q[MUL_LAT*M-1 -: M];

  always_comb begin
    pipe_d = {pipe_q[(MUL_LAT-1)*M-1:0], gf_mul(mul_a, b_q)};
  end

  always_comb begin
    start       = ~prev_o_q & bus.alu_o_sel;
    term_hit    = busy_q & (bus.inv_cSignal == TERM);
    prev_o_d    = bus.alu_o_sel;
    t_d         = t_q;
    b_d         = b_q;
    if (busy_q && in_en) begin
      t_d = in_sel ? bus.op_in : mul_out;
      b_d = t_d;
    end
    // A fresh start outranks termination; the TERM register update still lands.
    busy_d      = start | (busy_q & ~term_hit);
    res_valid_d = term_hit & ~start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q         <= '0;
      b_q         <= '0;
      pipe_q      <= '0;
      prev_o_q    <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      t_q         <= t_d;
      b_q         <= b_d;
      pipe_q      <= pipe_d;
      prev_o_q    <= prev_o_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.res_out   = t_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_inv_datapath.sv
// Bench for inv_datapath: a field-arithmetic reference model predicts T/busy every cycle and
// queues expected results; an independent monitor matches them against res_valid pulses.
module tb_inv_datapath;
  localparam int unsigned M         = 13;
  localparam logic [4:0]  TERM      = 5'b01100;
  localparam logic [13:0] POLY_FULL = 14'h201B;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_datapath_if #(.M(M)) bus ();

  inv_datapath #(
    .M       (M),
    .POLY    (13'h001B),
    .MUL_LAT (4),
    .TERM    (TERM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [M-1:0] exp_q[$];
  logic [M-1:0] m_pipe[$];
  logic [M-1:0] m_t    = '0;
  logic [M-1:0] m_b    = '0;
  bit           m_busy = 1'b0;
  bit           m_prev = 1'b0;
  logic [4:0]   opw [1:5];

  // Schoolbook product followed by long division by the full polynomial.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-2:0] p;
    logic [2*M-2:0] aa;
    p  = '0;
    aa = {{(M-1){1'b0}}, a};
    for (int i = 0; i < int'(M); i++) if (b[i]) p = p ^ (aa << i);
    for (int i = 2*M-2; i >= int'(M); i--)
      if (p[i]) p = p ^ ({{(M-2){1'b0}}, POLY_FULL} << (i - int'(M)));
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] gf_pow(input logic [M-1:0] a, input int e);
    logic [M-1:0] r;
    logic [M-1:0] base;
    int           ee;
    r    = 1;
    base = a;
    ee   = e;
    while (ee > 0) begin
      if (ee[0]) r = gf_mul(r, base);
      base = gf_mul(base, base);
      ee   = ee >> 1;
    end
    return r;
  endfunction

  // Controller word for step i (1..26) of a nominal inversion.
  function automatic logic [4:0] word_at(input int i);
    if (i == 1) return 5'b11000;
    if (i % 5 == 1) return (i == 26) ? TERM : 5'b01000;
    return opw[(i + 3) / 5];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then compare T and busy.
  task automatic cyc(input bit sel, input logic [4:0] w, input logic [M-1:0] op, input bit r);
    logic [M-1:0] nt, nb, a, mo;
    bit           st, term, nbusy;
    int           k;
    bus.alu_o_sel   = sel;
    bus.inv_cSignal = w;
    bus.op_in       = op;
    rst             = r;
    term            = 1'b0;
    if (r) begin
      nt    = '0;
      nb    = '0;
      nbusy = 1'b0;
      m_pipe.delete();
      for (int i = 0; i < 4; i++) m_pipe.push_back('0);
    end else begin
      st = !m_prev && sel;
      k  = w[1] ? 6 : (w[0] ? 3 : 1);
      a  = w[2] ? gf_pow(m_t, 1 << k) : m_t;
      mo = m_pipe.pop_front();
      m_pipe.push_back(gf_mul(a, m_b));
      nt = m_t;
      nb = m_b;
      if (m_busy && w[3]) begin
        nt = w[4] ? op : mo;
        nb = nt;
      end
      term  = m_busy && (w == TERM) && !st;
      nbusy = st || (m_busy && (w != TERM));
    end
    @(posedge clk);
    #1;
    m_prev = r ? 1'b0 : sel;
    m_t    = nt;
    m_b    = nb;
    m_busy = nbusy;
    if (term) exp_q.push_back(nt);
    chk("res_out", 32'(bus.res_out), 32'(m_t));
    chk("busy", 32'(bus.busy), 32'(m_busy));
  endtask

  task automatic start_pulse();
    cyc(1'b1, 5'b00000, '0, 1'b0);
  endtask

  task automatic run_words(input logic [M-1:0] op, input int first, input int last);
    for (int i = first; i <= last; i++) cyc(1'b0, word_at(i), op, 1'b0);
  endtask

  task automatic default_opw();
    opw[1] = 5'b00100;
    opw[2] = 5'b00101;
    opw[3] = 5'b00110;
    opw[4] = 5'b00000;
    opw[5] = 5'b00111;
  endtask

  always @(negedge clk) begin
    if (bus.res_valid === 1'b1 || exp_q.size() != 0) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_res_valid: got res_valid=1 res_out=0x%0h, expected none at %0t",
                 bus.res_out, $time);
      end else begin
        logic [M-1:0] e;
        e = exp_q.pop_front();
        if (bus.res_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL missing_res_valid: got res_valid=%b, expected 1 (result 0x%0h) at %0t",
                   bus.res_valid, e, $time);
        end else if (bus.res_out !== e) begin
          n_fail++;
          $display("FAIL result_value: got 0x%0h, expected 0x%0h at %0t", bus.res_out, e, $time);
        end
      end
    end
  end

  initial begin
    logic [M-1:0] op;
    default_opw();

    cyc(1'b0, 5'b00000, '0, 1'b1);
    cyc(1'b0, 5'b00000, '0, 1'b1);
    chk("reset_res_out", 32'(bus.res_out), 32'h0);
    chk("reset_res_valid", 32'(bus.res_valid), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);

    for (int i = 0; i < 3; i++) cyc(1'b0, 5'b11000, 13'h1234, 1'b0);
    chk("idle_load_ignored", 32'(bus.res_out), 32'h0);

    start_pulse();
    cyc(1'b0, 5'b11000, 13'h1000, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 5'b00000, 13'h1000, 1'b0);
    cyc(1'b0, 5'b01000, 13'h1000, 1'b0);
    chk("square_result", 32'(bus.res_out), 32'h185A);
    chk("square_busy", 32'(bus.busy), 32'h1);
    chk("square_no_valid", 32'(bus.res_valid), 32'h0);

    start_pulse();
    cyc(1'b0, 5'b11000, 13'h0002, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 5'b00101, 13'h0002, 1'b0);
    cyc(1'b0, 5'b01000, 13'h0002, 1'b0);
    chk("pow3_result", 32'(bus.res_out), 32'h0200);

    start_pulse();
    run_words(13'h0001, 1, 25);
    chk("full_busy_c26", 32'(bus.busy), 32'h1);
    run_words(13'h0001, 26, 26);
    chk("full_valid_c27", 32'(bus.res_valid), 32'h1);
    chk("full_result", 32'(bus.res_out), 32'h0001);
    chk("full_busy_fell", 32'(bus.busy), 32'h0);
    for (int i = 0; i < 20; i++) cyc(1'b0, TERM, 13'h0001, 1'b0);
    chk("term_held_no_valid", 32'(bus.res_valid), 32'h0);
    chk("term_held_stable", 32'(bus.res_out), 32'h0001);

    op = 13'h0ACE;
    start_pulse();
    run_words(op, 1, 11);
    cyc(1'b1, 5'b00000, op, 1'b0);
    run_words(op, 1, 14);
    chk("restart_no_early_valid", 32'(bus.res_valid), 32'h0);
    chk("restart_busy", 32'(bus.busy), 32'h1);
    run_words(op, 15, 26);
    chk("restart_valid", 32'(bus.res_valid), 32'h1);
    cyc(1'b0, TERM, op, 1'b0);

    start_pulse();
    run_words(op, 1, 9);
    cyc(1'b0, word_at(10), op, 1'b1);
    chk("midreset_res_out", 32'(bus.res_out), 32'h0);
    chk("midreset_busy", 32'(bus.busy), 32'h0);
    run_words(op, 11, 26);
    for (int i = 0; i < 5; i++) cyc(1'b0, TERM, op, 1'b0);
    chk("midreset_no_change", 32'(bus.res_out), 32'h0);
    chk("midreset_no_valid", 32'(bus.res_valid), 32'h0);

    for (int r = 0; r < 4; r++) begin
      for (int j = 1; j <= 5; j++) opw[j] = {2'b00, 3'($urandom_range(0, 7))};
      op = 13'($urandom_range(1, 8191));
      start_pulse();
      run_words(op, 1, 26);
      cyc(1'b0, TERM, op, 1'b0);
      cyc(1'b0, TERM, op, 1'b0);
    end

    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)), 13'($urandom_range(0, 8191)),
          ($urandom_range(0, 63) == 0));
    for (int i = 0; i < 3; i++) cyc(1'b0, 5'b00000, '0, 1'b0);

    chk("expect_queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
